// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial front end; define SERIALIZER_PARITY_EN to append an even-parity bit
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic             sout,
  output logic             sout_vld,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last, load;
  // Next-state, shift/count update and handshake; a load in the final bit cycle reloads without a gap
  always_comb begin
    last = state_q == SHIFT && cnt_q == '0;
`ifdef SERIALIZER_PARITY_EN
    din_rdy = state_q == IDLE || state_q == PAR;
    par_d = par_q;
`else
    din_rdy = state_q == IDLE || last;
`endif
    load = din_vld && din_rdy;
    state_d = state_q;
    sreg_d = sreg_q;
    cnt_d = cnt_q;
    if (state_q == SHIFT) begin
      sreg_d = sreg_q << 1;
      cnt_d = last ? cnt_q : cnt_q - CW'(1);
`ifdef SERIALIZER_PARITY_EN
      state_d = last ? PAR : SHIFT;
`else
      state_d = last ? IDLE : SHIFT;
`endif
    end
`ifdef SERIALIZER_PARITY_EN
    if (state_q == PAR) state_d = IDLE;
`endif
    if (load) begin
      state_d = SHIFT;
      sreg_d = din;
      cnt_d = CW'(WIDTH - 1);
`ifdef SERIALIZER_PARITY_EN
      par_d = ^din;
`endif
    end
`ifdef SERIALIZER_PARITY_EN
    sout = state_q == IDLE ? 1'b0 : state_q == PAR ? par_q : sreg_q[WIDTH-1];
`else
    sout = state_q == IDLE ? 1'b0 : sreg_q[WIDTH-1];
`endif
    sout_vld = state_q != IDLE;
    busy = state_q != IDLE;
  end
  // State registers; reset discards any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q <= '0;
      cnt_q <= '0;
`ifdef SERIALIZER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized check of bit_serializer against a queue-of-expected-bits model
module tb_bit_serializer;
  localparam int WIDTH = 8;
  logic clk = 0;
  logic rst = 0;
  logic [WIDTH-1:0] din = '0;
  logic din_vld = 0;
  logic din_rdy, sout, sout_vld, busy;
  int total = 0;
  int bad = 0;
  bit q[$];
  logic [31:0] cap = '0;
  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
    .din_rdy(din_rdy), .sout(sout), .sout_vld(sout_vld), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d, output bit acc);
    bit rdy;
    @(negedge clk);
    rst = r;
    din_vld = v;
    din = d;
    if (!r) q.delete();
    #1;
    rdy = q.size() <= 1;
    chk("sout", {31'b0, sout}, {31'b0, q.size() > 0 ? q[0] : 1'b0});
    chk("sout_vld", {31'b0, sout_vld}, {31'b0, q.size() > 0});
    chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
    chk("din_rdy", {31'b0, din_rdy}, {31'b0, rdy});
    if (sout_vld) cap = {cap[30:0], sout};
    acc = r && v && rdy;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      for (int i = WIDTH - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
      q.push_back(^d);
`endif
    end
  endtask
  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1, 0, WIDTH'($urandom), a);
  endtask
  task automatic send(input logic [WIDTH-1:0] w);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 100) begin
      cycle(1, 1, w, a);
      n++;
    end
    if (!a) chk("send_timeout", 0, 1);
  endtask
  initial begin
    bit a;
    for (int i = 0; i < 5; i++) cycle(0, 1'($urandom), WIDTH'($urandom), a);
    idle(2);
`ifdef SERIALIZER_PARITY_EN
    send(8'h07);
    idle(9);
    chk("par_07", {23'b0, cap[8:0]}, 32'h00F);
    send(8'h03);
    idle(9);
    chk("par_03", {23'b0, cap[8:0]}, 32'h006);
`else
    send(8'hB0);
    idle(8);
    chk("b0_stream", {24'b0, cap[7:0]}, 32'hB0);
    send(8'hA5);
    send(8'h3C);
    idle(8);
    chk("b2b_stream", {16'b0, cap[15:0]}, 32'hA53C);
    send(8'hB0);
    send(8'hFF);
    idle(8);
    chk("busy_ignore", {16'b0, cap[15:0]}, 32'hB0FF);
`endif
    send(8'hB0);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(0, 1'($urandom), WIDTH'($urandom), a);
    send(8'h80);
    idle(WIDTH + 1);
`ifndef SERIALIZER_PARITY_EN
    chk("post_reset_80", {24'b0, cap[7:0]}, 32'h80);
`endif
    for (int k = 0; k < 200; k++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 30) == 0)
        for (int i = 0; i < 2; i++) cycle(0, 1'($urandom), WIDTH'($urandom), a);
      send(WIDTH'($urandom));
    end
    idle(WIDTH + 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
